// File: rtl/uart_bus_responder_if.sv
// CPU data-memory port (MEM stage) as seen by the UART bus responder.
// The master drives the strobes, address and write data; the slave returns read data.
interface uart_bus_responder_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_bus_responder.sv
// Memory-mapped bridge between the CPU data port and the uart_rx/uart_tx engines:
// RX/TX byte FIFOs, a TX launch state machine and a level RX interrupt.
module uart_bus_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018,
  parameter int unsigned RX_AW     = 4,
  parameter int unsigned TX_AW     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  uart_bus_responder_if.slave       bus,
  input  logic                      RX_STATUS,
  input  logic [7:0]                RX_DATA,
  input  logic                      TX_STATUS,
  output logic                      TX_EN,
  output logic [7:0]                TX_DATA,
  output logic                      irqout
);
  localparam int unsigned RX_DEPTH = 2 ** RX_AW;
  localparam int unsigned TX_DEPTH = 2 ** TX_AW;
  localparam int unsigned RX_CW    = RX_AW + 1;
  localparam int unsigned TX_CW    = TX_AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_ACT  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

  logic [29:0]      word_s;
  logic             sel_txd_s, sel_rxd_s, sel_stat_s, sel_ctrl_s;
  logic             ctrl_wr_s;

  logic [7:0]       rx_mem_r [RX_DEPTH];
  logic [RX_AW-1:0] rx_wptr_r, rx_rptr_r;
  logic [RX_CW-1:0] rx_count_r;
  logic             rx_empty_s, rx_full_s, rx_push_s, rx_pop_s;
  logic [7:0]       rx_head_s, rx_count8_s;
  logic             rx_ovf_r, rx_ie_r;

  logic [7:0]       tx_mem_r [TX_DEPTH];
  logic [TX_AW-1:0] tx_wptr_r, tx_rptr_r;
  logic [TX_CW-1:0] tx_count_r;
  logic             tx_empty_s, tx_full_s, tx_push_s, tx_pop_s, tx_busy_s;
  logic             tx_drop_r;

  tx_state_e        state_r, state_next_s;
  logic             tx_en_r;
  logic [7:0]       tx_data_r;
  logic [31:0]      rdata_s;
  logic             unused_s;

  assign word_s     = bus.addr[31:2];
  assign sel_txd_s  = (word_s == BASE_ADDR[31:2]);
  assign sel_rxd_s  = (word_s == BASE_ADDR[31:2] + 30'd1);
  assign sel_stat_s = (word_s == BASE_ADDR[31:2] + 30'd2);
  assign sel_ctrl_s = (word_s == BASE_ADDR[31:2] + 30'd3);
  assign ctrl_wr_s  = bus.wr & sel_ctrl_s;
  assign unused_s   = ^{bus.wdata[31:8], bus.addr[1:0]};

  assign rx_empty_s  = (rx_count_r == RX_CW'(0));
  assign rx_full_s   = (rx_count_r == RX_CW'(RX_DEPTH));
  assign rx_head_s   = rx_mem_r[rx_rptr_r];
  assign rx_count8_s = 8'(rx_count_r);
  // A same-cycle pop never makes room for a push: fullness is judged on the old count.
  assign rx_push_s   = RX_STATUS & ~rx_full_s;
  assign rx_pop_s    = bus.rd & sel_rxd_s & ~rx_empty_s;

  assign tx_empty_s = (tx_count_r == TX_CW'(0));
  assign tx_full_s  = (tx_count_r == TX_CW'(TX_DEPTH));
  assign tx_push_s  = bus.wr & sel_txd_s & ~tx_full_s;
  assign tx_busy_s  = (state_r != ST_IDLE) | ~tx_empty_s;

  // RX FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wptr_r  <= '0;
      rx_rptr_r  <= '0;
      rx_count_r <= '0;
      rx_ovf_r   <= 1'b0;
    end else begin
      if (rx_push_s) rx_wptr_r <= rx_wptr_r + RX_AW'(1);
      if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + RX_AW'(1);
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_count_r <= rx_count_r + RX_CW'(1);
        2'b01:   rx_count_r <= rx_count_r - RX_CW'(1);
        default: rx_count_r <= rx_count_r;
      endcase
      if (RX_STATUS && rx_full_s)              rx_ovf_r <= 1'b1;
      else if (ctrl_wr_s && bus.wdata[1])      rx_ovf_r <= 1'b0;
    end
  end

  // RX byte storage
  always_ff @(posedge clk) begin
    if (rx_push_s) rx_mem_r[rx_wptr_r] <= RX_DATA;
  end

  // TX FIFO pointers, occupancy and sticky drop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wptr_r  <= '0;
      tx_rptr_r  <= '0;
      tx_count_r <= '0;
      tx_drop_r  <= 1'b0;
    end else begin
      if (tx_push_s) tx_wptr_r <= tx_wptr_r + TX_AW'(1);
      if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + TX_AW'(1);
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_count_r <= tx_count_r + TX_CW'(1);
        2'b01:   tx_count_r <= tx_count_r - TX_CW'(1);
        default: tx_count_r <= tx_count_r;
      endcase
      if (bus.wr && sel_txd_s && tx_full_s)    tx_drop_r <= 1'b1;
      else if (ctrl_wr_s && bus.wdata[2])      tx_drop_r <= 1'b0;
    end
  end

  // TX byte storage
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_r[tx_wptr_r] <= bus.wdata[7:0];
  end

  // Interrupt enable
  always_ff @(posedge clk) begin
    if (reset)          rx_ie_r <= 1'b0;
    else if (ctrl_wr_s) rx_ie_r <= bus.wdata[0];
    else                rx_ie_r <= rx_ie_r;
  end

  // TX launch state, data-valid pulse and held byte
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      tx_en_r   <= 1'b0;
      tx_data_r <= 8'h00;
    end else begin
      state_r <= state_next_s;
      tx_en_r <= tx_pop_s;
      if (tx_pop_s) tx_data_r <= tx_mem_r[tx_rptr_r];
    end
  end

  // TX launch next-state: the head leaves the FIFO when the line is idle
  always_comb begin
    state_next_s = state_r;
    tx_pop_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!tx_empty_s && !TX_STATUS) begin
          state_next_s = ST_LAUNCH;
          tx_pop_s     = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LAUNCH:    state_next_s = ST_WAIT_ACT;
      ST_WAIT_ACT: begin
        if (TX_STATUS) state_next_s = ST_WAIT_DONE;
        else           state_next_s = ST_WAIT_ACT;
      end
      ST_WAIT_DONE: begin
        if (!TX_STATUS) state_next_s = ST_IDLE;
        else            state_next_s = ST_WAIT_DONE;
      end
      default:      state_next_s = ST_IDLE;
    endcase
  end

  // Read mux; an empty RX FIFO reads as zero rather than stale storage
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (bus.rd) begin
      if (sel_rxd_s) begin
        if (!rx_empty_s) rdata_s = {24'h00_0000, rx_head_s};
        else             rdata_s = 32'h0000_0000;
      end else if (sel_stat_s) begin
        rdata_s = {16'h0000, rx_count8_s, 2'b00, tx_drop_r, rx_ovf_r, rx_ie_r,
                   tx_busy_s, tx_full_s, ~rx_empty_s};
      end else if (sel_ctrl_s) begin
        rdata_s = {31'h0000_0000, rx_ie_r};
      end else begin
        rdata_s = 32'h0000_0000;
      end
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign bus.rdata = rdata_s;
  assign TX_EN     = tx_en_r;
  assign TX_DATA   = tx_data_r;
  assign irqout    = rx_ie_r & ~rx_empty_s;
endmodule

// File: tb/tb_uart_bus_responder.sv
// Randomised scoreboard bench: a queue-based reference model predicts read data,
// TX launches (byte and cycle) and the interrupt; a negedge monitor checks them.
module tb_uart_bus_responder;
  localparam logic [31:0] A_TXD  = 32'h4000_0018;
  localparam logic [31:0] A_RXD  = 32'h4000_001C;
  localparam logic [31:0] A_STAT = 32'h4000_0020;
  localparam logic [31:0] A_CTRL = 32'h4000_0024;
  localparam int DEPTH = 16;

  typedef struct { int cyc; logic [7:0] data; } tx_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx_status = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic uart_busy = 1'b0;
  logic ext_busy = 1'b0;
  logic tx_status;
  logic tx_en;
  logic [7:0] tx_data;
  logic irqout;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  // reference model state
  logic [7:0] m_rx[$];
  logic [7:0] m_tx[$];
  logic m_ovf = 1'b0, m_drop = 1'b0, m_ie = 1'b0;
  logic m_inflight = 1'b0, m_seen = 1'b0;
  logic exp_irq = 1'b0;
  logic [31:0] rd_q[$];
  tx_exp_t exp_tx[$];

  uart_bus_responder_if bus ();

  assign tx_status = uart_busy | ext_busy;

  uart_bus_responder dut (
    .clk(clk), .reset(reset), .bus(bus),
    .RX_STATUS(rx_status), .RX_DATA(rx_data),
    .TX_STATUS(tx_status), .TX_EN(tx_en), .TX_DATA(tx_data),
    .irqout(irqout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (a[31:2] == A_RXD[31:2])
      r = (m_rx.size() > 0) ? {24'h0, m_rx[0]} : 32'h0;
    else if (a[31:2] == A_STAT[31:2])
      r = {16'h0, 8'(m_rx.size()), 2'b00, m_drop, m_ovf, m_ie,
           (m_inflight || m_tx.size() > 0), (m_tx.size() == DEPTH), (m_rx.size() > 0)};
    else if (a[31:2] == A_CTRL[31:2])
      r = {31'h0, m_ie};
    return r;
  endfunction

  // State change of the model at one clock edge, from the inputs seen before it.
  task automatic model_edge(input logic rd_i, input logic wr_i, input logic [31:0] a,
                            input logic [31:0] wd, input logic rxs, input logic [7:0] rxd,
                            input logic rst_i, input logic ts);
    logic rx_was_full, tx_was_full, launch;
    if (rst_i) begin
      m_rx.delete(); m_tx.delete();
      m_ovf = 1'b0; m_drop = 1'b0; m_ie = 1'b0; m_inflight = 1'b0; m_seen = 1'b0;
    end else begin
      rx_was_full = (m_rx.size() == DEPTH);
      tx_was_full = (m_tx.size() == DEPTH);
      launch = !m_inflight && (m_tx.size() > 0) && !ts;
      if (wr_i && a[31:2] == A_CTRL[31:2]) begin
        m_ie = wd[0];
        if (wd[1]) m_ovf = 1'b0;
        if (wd[2]) m_drop = 1'b0;
      end
      if (rd_i && a[31:2] == A_RXD[31:2] && m_rx.size() > 0) void'(m_rx.pop_front());
      if (rxs) begin
        if (rx_was_full) m_ovf = 1'b1;
        else m_rx.push_back(rxd);
      end
      if (m_inflight) begin
        if (ts) m_seen = 1'b1;
        else if (m_seen) m_inflight = 1'b0;
      end
      if (launch) begin
        exp_tx.push_back('{cyc: cyc + 1, data: m_tx.pop_front()});
        m_inflight = 1'b1;
        m_seen = 1'b0;
      end
      if (wr_i && a[31:2] == A_TXD[31:2]) begin
        if (tx_was_full) m_drop = 1'b1;
        else m_tx.push_back(wd[7:0]);
      end
    end
    exp_irq = m_ie && (m_rx.size() > 0);
  endtask

  // One bus cycle: drive, predict read data, clock, advance the model.
  task automatic drive(input logic rd_i, input logic wr_i, input logic [31:0] a,
                       input logic [31:0] wd, input logic rxs, input logic [7:0] rxd,
                       input logic rst_i);
    logic ts;
    bus.rd = rd_i; bus.wr = wr_i; bus.addr = a; bus.wdata = wd;
    rx_status = rxs; rx_data = rxd; reset = rst_i;
    if (rd_i) rd_q.push_back(model_rdata(a));
    @(posedge clk);
    ts = tx_status;
    model_edge(rd_i, wr_i, a, wd, rxs, rxd, rst_i, ts);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rd_reg(input logic [31:0] a);
    drive(1'b1, 1'b0, a, 32'h0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, d, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, b, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_tx.size() > 0 || m_inflight || uart_busy) && n < 3000) begin
      idle(1);
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL drain_timeout: TX queue did not empty, %0d bytes left", m_tx.size());
    end
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0, 1:    a = A_TXD;
      2, 3:    a = A_RXD;
      4, 5:    a = A_STAT;
      6:       a = A_CTRL;
      7:       a = A_TXD ^ 32'h0100_0000;
      8:       a = A_STAT + 32'h10;
      default: a = A_CTRL ^ 32'h8000_0000;
    endcase
    a[1:0] = 2'($urandom_range(0, 3));
    return a;
  endfunction

  // uart_tx stand-in: goes busy 1-2 cycles after a TX_EN pulse for a random frame time
  initial begin
    forever begin
      @(negedge clk);
      if (tx_en === 1'b1) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1 uart_busy = 1'b1;
        repeat ($urandom_range(3, 10)) @(posedge clk);
        #1 uart_busy = 1'b0;
      end
    end
  end

  // Monitor: compares DUT outputs against the model's predictions
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.rd) begin
        if (rd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rdata_unpredicted: got %h with no expectation queued", bus.rdata);
        end else check("rdata", bus.rdata, rd_q.pop_front());
      end else check("rdata_idle", bus.rdata, 32'h0);
      check("irqout", {31'h0, irqout}, {31'h0, exp_irq});
      while (exp_tx.size() > 0 && exp_tx[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL tx_en_missed: byte %h expected at cycle %0d, now %0d",
                 exp_tx[0].data, exp_tx[0].cyc, cyc);
        void'(exp_tx.pop_front());
      end
      if (tx_en === 1'b1) begin
        check("tx_en_while_busy", {31'h0, tx_status}, 32'h0);
        if (exp_tx.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_en_unexpected: got TX_EN with data %h, expected none", tx_data);
        end else begin
          check("tx_data", {24'h0, tx_data}, {24'h0, exp_tx[0].data});
          check("tx_en_cycle", cyc, exp_tx[0].cyc);
          void'(exp_tx.pop_front());
        end
      end else if (tx_en !== 1'b0) begin
        check("tx_en_known", {31'h0, tx_en}, 32'h0);
      end
    end
  end

  initial begin
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b1);
    mon_en = 1'b1;

    // reset state, then two back-to-back TX bytes
    rd_reg(A_STAT); rd_reg(A_CTRL); rd_reg(A_RXD); rd_reg(A_TXD);
    wr_reg(A_TXD, 32'hDEAD_BE41);
    wr_reg(A_TXD, 32'h0000_0042);
    rd_reg(A_STAT);
    drain();
    rd_reg(A_STAT);

    // fill RX past depth, read everything back plus one
    for (int i = 0; i < 16; i++) rx_byte(8'(8'h10 + i));
    rx_byte(8'h55);
    rd_reg(A_STAT);
    for (int i = 0; i < 17; i++) rd_reg(A_RXD);
    rd_reg(A_STAT);

    // interrupt path and overflow clear
    wr_reg(A_CTRL, 32'h1);
    rx_byte(8'hA5);
    idle(1);
    rd_reg(A_RXD);
    idle(1);
    wr_reg(A_CTRL, 32'h3);
    rd_reg(A_STAT);

    // simultaneous push and pop at count 3, then at full
    for (int i = 0; i < 3; i++) rx_byte(8'(8'h60 + i));
    drive(1'b1, 1'b0, A_RXD, 32'h0, 1'b1, 8'h77, 1'b0);
    rd_reg(A_STAT);
    for (int i = 0; i < 13; i++) rx_byte(8'(8'h80 + i));
    rd_reg(A_STAT);
    drive(1'b1, 1'b0, A_RXD, 32'h0, 1'b1, 8'h99, 1'b0);
    rd_reg(A_STAT);
    for (int i = 0; i < 16; i++) rd_reg(A_RXD);
    wr_reg(A_CTRL, 32'h2);

    // line held busy: TX FIFO fills, 17th byte dropped, nothing launches
    ext_busy = 1'b1;
    for (int i = 0; i < 17; i++) wr_reg(A_TXD, 32'(8'hC0 + i));
    idle(5);
    rd_reg(A_STAT);
    ext_busy = 1'b0;
    drain();
    rd_reg(A_STAT);
    wr_reg(A_CTRL, 32'h4);
    rd_reg(A_STAT);

    // reset while a frame is on the line and bytes are queued
    for (int i = 0; i < 6; i++) wr_reg(A_TXD, 32'(8'hE0 + i));
    for (int n = 0; n < 50 && !uart_busy; n++) idle(1);
    check("frame_started", {31'h0, uart_busy}, 32'h1);
    idle(1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b1);
    rd_reg(A_STAT);
    idle(30);
    rd_reg(A_STAT);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, w, x, rs;
      r  = ($urandom_range(0, 99) < 30);
      w  = ($urandom_range(0, 99) < 25);
      x  = ($urandom_range(0, 99) < 30);
      rs = ($urandom_range(0, 999) == 0);
      if (rs) r = 1'b0;
      drive(r, w, pick_addr(), $urandom, x, 8'($urandom), rs);
    end
    drain();
    rd_reg(A_STAT);
    idle(3);

    check("rd_queue_left", rd_q.size(), 32'h0);
    check("tx_queue_left", exp_tx.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
